// File: rtl/timer_base_gen_if.sv
// Bundle of the timer time-base control and status signals.
// The master side owns run and the divisor write port; the slave side
// (timer_base_gen) returns the two time-bases plus divisor status.
//
// The divisor write port has no ready. A write is taken when wr_en is
// high on a rising clk edge. wr_err pulses for one clk when a write
// was rejected.
interface timer_base_gen_if #(
  parameter int DIV_W = 16
);
  logic             run;
  logic             wr_en;
  logic             wr_sel;
  logic [DIV_W-1:0] wr_data;
  logic             wr_err;
  logic             tb1_tick;
  logic             tb1_clk;
  logic             tb2_tick;
  logic             tb2_clk;
  logic [DIV_W-1:0] div1;
  logic [DIV_W-1:0] div2;
  logic             pend1;
  logic             pend2;

  modport master (
    output run, wr_en, wr_sel, wr_data,
    input  wr_err, tb1_tick, tb1_clk, tb2_tick, tb2_clk,
    input  div1, div2, pend1, pend2
  );

  modport slave (
    input  run, wr_en, wr_sel, wr_data,
    output wr_err, tb1_tick, tb1_clk, tb2_tick, tb2_clk,
    output div1, div2, pend1, pend2
  );
endinterface

// File: rtl/timer_base_gen.sv
// Two independent programmable clock dividers that produce the timer
// time-bases. Each channel emits a 1-clk tick per period and a registered
// square wave whose rising edge lines up with the tick. While running,
// divisor writes are held in a shadow register and only take effect at a
// period boundary, so downstream timers never see a shortened period.
module timer_base_gen #(
  parameter int DIV_W       = 16,
  parameter int TB1_DEFAULT = 1000,
  parameter int TB2_DEFAULT = 10
) (
  input  logic             clk,
  input  logic             reset,
  timer_base_gen_if.slave  bus
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  // Per-channel state; index 0 is tb1, index 1 is tb2.
  logic [DIV_W-1:0] cnt_q    [2];
  logic [DIV_W-1:0] cnt_d    [2];
  logic [DIV_W-1:0] div_q    [2];
  logic [DIV_W-1:0] div_d    [2];
  logic [DIV_W-1:0] shadow_q [2];
  logic [DIV_W-1:0] shadow_d [2];
  logic             pend_q   [2];
  logic             pend_d   [2];
  logic             tick_q   [2];
  logic             tick_d   [2];
  logic             clk_q    [2];
  logic             clk_d    [2];
  logic             wr_err_q;
  logic             wr_err_d;

  logic             wr_ok;
  logic             wr_hit   [2];
  logic             wrap     [2];

  // Next-state for both channels: counter, divisor apply, shadow capture.
  always_comb begin
    wr_ok    = (bus.wr_data >= TWO);
    wr_err_d = bus.wr_en & ~wr_ok;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]    = cnt_q[i];
      div_d[i]    = div_q[i];
      shadow_d[i] = shadow_q[i];
      pend_d[i]   = pend_q[i];
      wr_hit[i]   = bus.wr_en & wr_ok & (bus.wr_sel == 1'(i));
      wrap[i]     = bus.run & (cnt_q[i] == (div_q[i] - ONE));

      if (bus.run) begin
        if (wrap[i]) begin
          cnt_d[i] = '0;
          // Period boundary: a previously queued divisor takes over here.
          if (pend_q[i]) begin
            div_d[i]  = shadow_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
        // A write landing on the wrap edge still waits for the next wrap.
        if (wr_hit[i]) begin
          shadow_d[i] = bus.wr_data;
          pend_d[i]   = 1'b1;
        end
      end else begin
        // Stopped: counter cleared, anything queued is applied right away.
        cnt_d[i] = '0;
        if (pend_q[i]) begin
          div_d[i]  = shadow_q[i];
          pend_d[i] = 1'b0;
        end
        if (wr_hit[i]) begin
          div_d[i]  = bus.wr_data;
          pend_d[i] = 1'b0;
        end
      end

      tick_d[i] = wrap[i];
      // High for the first floor(d/2) counts of each period.
      clk_d[i]  = bus.run & (cnt_d[i] < (div_d[i] >> 1));
    end
  end

  // State registers with asynchronous reset to the power-on divisors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
        pend_q[i]   <= 1'b0;
        tick_q[i]   <= 1'b0;
        clk_q[i]    <= 1'b0;
      end
      div_q[0] <= DIV_W'(TB1_DEFAULT);
      div_q[1] <= DIV_W'(TB2_DEFAULT);
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]    <= cnt_d[i];
        div_q[i]    <= div_d[i];
        shadow_q[i] <= shadow_d[i];
        pend_q[i]   <= pend_d[i];
        tick_q[i]   <= tick_d[i];
        clk_q[i]    <= clk_d[i];
      end
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.wr_err   = wr_err_q;
  assign bus.tb1_tick = tick_q[0];
  assign bus.tb1_clk  = clk_q[0];
  assign bus.tb2_tick = tick_q[1];
  assign bus.tb2_clk  = clk_q[1];
  assign bus.div1     = div_q[0];
  assign bus.div2     = div_q[1];
  assign bus.pend1    = pend_q[0];
  assign bus.pend2    = pend_q[1];

endmodule

// File: tb/tb_timer_base_gen.sv
// Directed bench for timer_base_gen. Each driven cycle pushes the
// hand-derived output vector expected after the next rising edge; a
// monitor pops and compares one entry per edge.
module tb_timer_base_gen;

  localparam int DIV_W = 16;
  localparam int W     = 7 + 2 * DIV_W;

  logic clk;
  logic reset;

  timer_base_gen_if #(.DIV_W(DIV_W)) bif ();

  timer_base_gen #(
    .DIV_W      (DIV_W),
    .TB1_DEFAULT(4),
    .TB2_DEFAULT(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0]     exp_q[$];
  int               vec_cnt;
  int               err_cnt;
  logic [DIV_W-1:0] cur_d1, cur_d2;
  logic             cur_p1, cur_p2;

  function automatic logic [W-1:0] actual_vec();
    return {bif.tb1_tick, bif.tb1_clk, bif.tb2_tick, bif.tb2_clk,
            bif.wr_err, bif.pend1, bif.pend2, bif.div1, bif.div2};
  endfunction

  // Monitor: one expected vector per rising edge while the queue has work.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        e = exp_q.pop_front();
        a = actual_vec();
        vec_cnt++;
        if (a !== e)
          begin
            err_cnt++;
            $display("FAIL vec%0d got=%h exp=%h", vec_cnt, a, e);
          end
      end
    end
  end

  // Immediate comparison, used where no clock edge is involved.
  task automatic check_now(input string name, input logic [W-1:0] e);
    logic [W-1:0] a;
    a = actual_vec();
    vec_cnt++;
    if (a !== e) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", name, a, e);
    end
  endtask

  // Driver: set inputs at negedge, queue the outputs expected after the edge.
  task automatic cyc(input logic r, input logic we, input logic sel,
                     input logic [DIV_W-1:0] data,
                     input logic [1:0] t1, input logic [1:0] t2,
                     input logic err);
    bif.run     = r;
    bif.wr_en   = we;
    bif.wr_sel  = sel;
    bif.wr_data = data;
    exp_q.push_back({t1, t2, err, cur_p1, cur_p2, cur_d1, cur_d2});
    @(negedge clk);
  endtask

  // Run n cycles with no writes; patterns are {tick,clk} pairs, first cycle leftmost.
  task automatic seq(input int n, input logic [63:0] a, input logic [63:0] b);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b0, 1'b0, '0, a[2*(n-1-i) +: 2], b[2*(n-1-i) +: 2], 1'b0);
  endtask

  initial begin
    vec_cnt     = 0;
    err_cnt     = 0;
    bif.run     = 1'b0;
    bif.wr_en   = 1'b0;
    bif.wr_sel  = 1'b0;
    bif.wr_data = '0;
    cur_d1 = 16'd4; cur_d2 = 16'd3; cur_p1 = 1'b0; cur_p2 = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_now("reset_vals", {7'b0, 16'd4, 16'd3});
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0);

    // 1: defaults d1=4 (HHLL), d2=3 (HLL); first tb1 tick on the 4th edge
    seq(12, 24'b01_00_00_11_01_00_00_11_01_00_00_11,
            24'b00_00_11_00_00_11_00_00_11_00_00_11);

    // 2: mid-period write of 6 to tb1; current period stays 4
    cyc(1'b1, 1'b0, 1'b0, '0,     2'b01, 2'b00, 1'b0);
    cur_p1 = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 16'd6,  2'b00, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0,     2'b00, 2'b11, 1'b0);
    cur_p1 = 1'b0; cur_d1 = 16'd6;
    cyc(1'b1, 1'b0, 1'b0, '0,     2'b11, 2'b00, 1'b0);
    seq(12, 24'b01_01_00_00_00_11_01_01_00_00_00_11,
            24'b00_11_00_00_11_00_00_11_00_00_11_00);

    // 3: rejected writes (1 to tb1, 0 to tb2)
    cyc(1'b1, 1'b1, 1'b0, 16'd1,  2'b01, 2'b00, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0,     2'b01, 2'b11, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 16'd0,  2'b00, 2'b00, 1'b1);
    seq(3, 6'b00_00_11, 6'b00_11_00);

    // 4: write on the wrap edge, then a second write; only 5 is applied
    seq(5, 10'b01_01_00_00_00, 10'b00_11_00_00_11);
    cur_p1 = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 16'd8,  2'b11, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0,     2'b01, 2'b00, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 16'd5,  2'b01, 2'b11, 1'b0);
    seq(3, 6'b00_00_00, 6'b00_00_11);
    cur_p1 = 1'b0; cur_d1 = 16'd5;
    cyc(1'b1, 1'b0, 1'b0, '0,     2'b11, 2'b00, 1'b0);
    seq(5, 10'b01_00_00_00_11, 10'b00_11_00_00_11);

    // 5: stop with pend2 set, write while stopped, then restart
    cur_p2 = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 16'd5,  2'b01, 2'b00, 1'b0);
    cur_p2 = 1'b0; cur_d2 = 16'd5;
    cyc(1'b0, 1'b0, 1'b0, '0,     2'b00, 2'b00, 1'b0);
    cur_d1 = 16'd2;
    cyc(1'b0, 1'b1, 1'b0, 16'd2,  2'b00, 2'b00, 1'b0);
    seq(5, 10'b00_11_00_11_00, 10'b01_00_00_00_11);

    // 6: async reset while tb1_clk is high, with a tb2 write pending
    cur_p2 = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 16'd9,  2'b11, 2'b01, 1'b0);
    reset = 1'b1;
    #1;
    check_now("async_reset", {7'b0, 16'd4, 16'd3});
    cur_d1 = 16'd4; cur_d2 = 16'd3; cur_p1 = 1'b0; cur_p2 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // Discarded shadow: tb2 keeps d=3 across its first wrap
    seq(4, 8'b01_00_00_11, 8'b00_00_11_00);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
